// File: rtl/register_toggle_multi_pkg.sv
// Shared constants and helpers for the register_toggle_multi toggle bank.
package register_toggle_multi_pkg;

    localparam int DIVIDE_WIDTH_DEFAULT = 4;

    // Low bit of channel ch's divisor field in the packed divisor bus.
    function automatic int unsigned divisor_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

    // A zero divisor behaves as divide-by-one.
    function automatic int unsigned effective_divisor(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/register_toggle_channel.sv
// One toggle slice: state bit, prescale counter, registered change flag and fire carry.
module register_toggle_channel
    import register_toggle_multi_pkg::*;
#(
    parameter int   DIVIDE_WIDTH = DIVIDE_WIDTH_DEFAULT,
    parameter logic RESET_BIT    = 1'b0
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    clock_enable,
    input  logic                    clear,
    input  logic                    toggle_eff,
    input  logic                    load,
    input  logic                    data_in,
    input  logic [DIVIDE_WIDTH-1:0] divisor,
    output logic                    state,
    output logic                    changed,
    output logic                    carry
);

    localparam logic [DIVIDE_WIDTH-1:0] CNT_ONE = 1;

    logic [DIVIDE_WIDTH-1:0] cnt;
    logic [DIVIDE_WIDTH-1:0] next_cnt;
    logic                    next_state;
    logic                    at_limit;

    // >= rather than == so a divisor shrunk below the running count fires at once.
    assign at_limit = (32'(cnt) >= effective_divisor(32'(divisor)) - 32'd1);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        carry      = 1'b0;
        if (clock_enable) begin
            if (clear) begin
                next_state = RESET_BIT;
                next_cnt   = '0;
            end else if (load) begin
                next_state = data_in;
                next_cnt   = '0;
            end else if (toggle_eff) begin
                if (at_limit) begin
                    next_state = ~state;
                    next_cnt   = '0;
                    carry      = state;
                end else begin
                    next_cnt   = cnt + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= RESET_BIT;
            cnt     <= '0;
            changed <= 1'b0;
        end else if (clock_enable) begin
            state   <= next_state;
            cnt     <= next_cnt;
            changed <= next_state ^ state;
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: rtl/register_toggle_multi.sv
// Bank of CHANNELS toggle FSMs with per-channel divisors.
// Define REGISTER_TOGGLE_MULTI_CASCADE_EN to ripple carries between channels (binary counter mode).
module register_toggle_multi
    import register_toggle_multi_pkg::*;
#(
    parameter int                  CHANNELS     = 4,
    parameter int                  DIVIDE_WIDTH = DIVIDE_WIDTH_DEFAULT,
    parameter logic [CHANNELS-1:0] RESET_VALUE  = '0
) (
    input  logic                             clock,
    input  logic                             clear_n,
    input  logic                             clock_enable,
    input  logic                             clear,
    input  logic [CHANNELS-1:0]              toggle,
    input  logic [CHANNELS-1:0]              load,
    input  logic [CHANNELS-1:0]              data_in,
    input  logic [CHANNELS*DIVIDE_WIDTH-1:0] divisor,
    output logic [CHANNELS-1:0]              data_out,
    output logic [CHANNELS-1:0]              changed
);

    for (genvar i = 0; i < CHANNELS; i++) begin : chan
        logic toggle_eff;
        logic carry;
        logic unused_carry;

        if (i == 0) begin : head
            assign toggle_eff = toggle[0];
        end else begin : body
`ifdef REGISTER_TOGGLE_MULTI_CASCADE_EN
            // Carry from the lower channel merges with the local request as one toggle.
            assign toggle_eff = toggle[i] | chan[i-1].carry;
`else
            assign toggle_eff = toggle[i];
`endif
        end

        assign unused_carry = carry;

        register_toggle_channel #(
            .DIVIDE_WIDTH (DIVIDE_WIDTH),
            .RESET_BIT    (RESET_VALUE[i])
        ) u_channel (
            .clock        (clock),
            .clear_n      (clear_n),
            .clock_enable (clock_enable),
            .clear        (clear),
            .toggle_eff   (toggle_eff),
            .load         (load[i]),
            .data_in      (data_in[i]),
            .divisor      (divisor[divisor_lo(i, DIVIDE_WIDTH) +: DIVIDE_WIDTH]),
            .state        (data_out[i]),
            .changed      (changed[i]),
            .carry        (carry)
        );
    end

endmodule

// File: tb/tb_register_toggle_multi.sv
// Directed-vector bench for register_toggle_multi (4 channels, RESET_VALUE 4'b0101).
module tb_register_toggle_multi;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        clock_enable;
    logic        clear;
    logic [3:0]  toggle;
    logic [3:0]  load;
    logic [3:0]  data_in;
    logic [15:0] divisor;
    logic [3:0]  data_out;
    logic [3:0]  changed;

    int vectors     = 0;
    int miscompares = 0;

    register_toggle_multi #(
        .CHANNELS     (4),
        .DIVIDE_WIDTH (4),
        .RESET_VALUE  (4'b0101)
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .clock_enable (clock_enable),
        .clear        (clear),
        .toggle       (toggle),
        .load         (load),
        .data_in      (data_in),
        .divisor      (divisor),
        .data_out     (data_out),
        .changed      (changed)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        clear_n      = 1'b0;
        clock_enable = 1'b1;
        clear        = 1'b0;
        toggle       = 4'b0000;
        load         = 4'b0000;
        data_in      = 4'b0000;
        divisor      = {4'd0, 4'd0, 4'd0, 4'd3};

        // Reset state
        tick();
        check("reset_data", data_out, 4'b0101);
        check("reset_changed", changed, 4'b0000);
        clear_n = 1'b1;

        // Divide by 3 on channel 0: flips after requests 3, 6 and 9
        toggle = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("div3_data_%0d", k), data_out,
                  {3'b010, ((k >= 3 && k < 6) || k >= 9) ? 1'b0 : 1'b1});
            check($sformatf("div3_changed_%0d", k), changed,
                  (k % 3 == 0) ? 4'b0001 : 4'b0000);
        end
        toggle = 4'b0000;
        tick();
        check("div3_idle_changed", changed, 4'b0000);

        // Async reset mid-count: ch0 cnt=1, ch2 just flipped
        toggle = 4'b0101;
        tick();
        check("midcount_data", data_out, 4'b0000);
        check("midcount_changed", changed, 4'b0100);
        toggle  = 4'b0000;
        clear_n = 1'b0;
        #1;
        check("async_reset_data", data_out, 4'b0101);
        check("async_reset_changed", changed, 4'b0000);
        tick();
        clear_n = 1'b1;
        toggle  = 4'b0001;
        tick();
        tick();
        check("post_reset_cnt_hold", data_out, 4'b0101);
        tick();
        check("post_reset_fire", data_out, 4'b0100);
        check("post_reset_changed", changed, 4'b0001);
        toggle = 4'b0000;

        // Priority: load beats toggle and zeroes cnt; clear beats load
        divisor = {4'd0, 4'd0, 4'd2, 4'd3};
        toggle  = 4'b0010;
        tick();
        check("prio_pre_count", data_out, 4'b0100);
        load    = 4'b0010;
        data_in = 4'b0010;
        tick();
        check("prio_load_data", data_out, 4'b0110);
        check("prio_load_changed", changed, 4'b0010);
        load    = 4'b0000;
        data_in = 4'b0000;
        tick();
        check("prio_cnt_zeroed", data_out, 4'b0110);
        check("prio_cnt_zeroed_changed", changed, 4'b0000);
        tick();
        check("prio_fire_after_load", data_out, 4'b0100);
        toggle  = 4'b0000;
        load    = 4'b0010;
        data_in = 4'b0010;
        tick();
        check("prio_reload", data_out, 4'b0110);
        clear   = 1'b1;
        toggle  = 4'b0010;
        tick();
        check("prio_clear_data", data_out, 4'b0101);
        check("prio_clear_changed", changed, 4'b0011);
        clear   = 1'b0;
        load    = 4'b0000;
        data_in = 4'b0000;
        toggle  = 4'b0000;

        // Divisor 0 acts as 1
        toggle = 4'b0100;
        tick();
        check("div0_a", data_out, 4'b0001);
        tick();
        check("div0_b", data_out, 4'b0101);
        tick();
        check("div0_c", data_out, 4'b0001);
        check("div0_changed", changed, 4'b0100);

        // cnt=4 with divisor 8, then shrink divisor to 2
        divisor = {4'd8, 4'd0, 4'd2, 4'd3};
        toggle  = 4'b1000;
        for (int k = 0; k < 4; k++) tick();
        check("div8_no_fire", data_out, 4'b0001);
        divisor = {4'd2, 4'd0, 4'd2, 4'd3};
        tick();
        check("shrink_fire", data_out, 4'b1001);
        check("shrink_changed", changed, 4'b1000);
        tick();
        check("shrink_cnt_zeroed", data_out, 4'b1001);
        tick();
        check("shrink_next_fire", data_out, 4'b0001);
        toggle = 4'b0000;

        // clock_enable low holds everything, even with clear asserted
        toggle = 4'b0101;
        tick();
        check("ce_pre_data", data_out, 4'b0101);
        check("ce_pre_changed", changed, 4'b0100);
        clock_enable = 1'b0;
        toggle       = 4'b1111;
        clear        = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("ce_hold_data_%0d", k), data_out, 4'b0101);
            check($sformatf("ce_hold_changed_%0d", k), changed, 4'b0000);
        end
        clock_enable = 1'b1;
        clear        = 1'b0;
        toggle       = 4'b0001;
        tick();
        check("ce_cnt_held", data_out, 4'b0101);
        tick();
        check("ce_resume_fire", data_out, 4'b0100);
        check("ce_resume_changed", changed, 4'b0001);
        toggle = 4'b0000;

`ifdef REGISTER_TOGGLE_MULTI_CASCADE_EN
        // Ripple counter: all divisors 1, count on toggle[0]
        divisor = 16'h0000;
        load    = 4'b1111;
        data_in = 4'b0000;
        tick();
        check("casc_load", data_out, 4'b0000);
        load   = 4'b0000;
        toggle = 4'b0001;
        begin
            logic [3:0] prev;
            logic [3:0] want;
            prev = 4'b0000;
            for (int k = 1; k <= 16; k++) begin
                want = 4'(k);
                tick();
                check($sformatf("casc_data_%0d", k), data_out, want);
                check($sformatf("casc_changed_%0d", k), changed, want ^ prev);
                prev = want;
            end
        end
        toggle = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
